rr_mux_arbiter: RTL and testbench

- Shares one W-bit N:1 multiplexer between N requesters using round-robin arbitration.
- Drives the mux select from a registered grant and captures the selected input into an output register.
- Presents the captured word downstream with a valid/ready handshake.
- Sits between independent producers and a single shared consumer path.

---
 rtl/rr_mux_arbiter.sv | 98 +++++++++
 tb/tb_rr_mux_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 mux arbiter with registered grant/select and a valid/ready output stage.
// Define RR_ARB_FIXED_PRIO_EN to switch arbitration to fixed lowest-index-first priority.
module rr_mux_arbiter #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*W-1:0]  in,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] sel,
   output logic [W-1:0]    o,
   output logic            o_valid,
   input  logic            o_ready
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          r_state, w_state_nxt;
   logic [SELW-1:0] r_ptr, r_sel, w_win;
   logic [N-1:0]    r_ack, r_gnt, w_ereq, w_win_oh;
   logic [W-1:0]    r_o;
   logic            r_valid, w_capture;

   // A requester is masked while its ack is out so it cannot be captured twice.
   assign w_ereq   = req & ~r_ack;
   assign w_win_oh = {{(N-1){1'b0}}, 1'b1} << w_win;

   always_comb begin
      int idx;
      idx   = 0;
      w_win = '0;
`ifdef RR_ARB_FIXED_PRIO_EN
      for (int i = N-1; i >= 0; i--)
         if (w_ereq[i]) w_win = SELW'(i);
`else
      // Walk from farthest to nearest so the nearest set bit after ptr wins.
      for (int k = N; k >= 1; k--) begin
         idx = (int'(r_ptr) + k) % N;
         if (w_ereq[idx]) w_win = SELW'(idx);
      end
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: if (|w_ereq) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
         end
         HOLD: if (o_ready) begin
            if (|w_ereq) w_capture   = 1'b1;
            else         w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= SELW'(N-1);
         r_sel   <= '0;
         r_o     <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_ack <= w_capture ? w_win_oh : '0;
         if (w_capture) begin
            r_o     <= in[int'(w_win)*W +: W];
            r_sel   <= w_win;
            r_gnt   <= w_win_oh;
            r_ptr   <= w_win;
            r_valid <= 1'b1;
         end else if (r_state == HOLD && o_ready) begin
            r_valid <= 1'b0;
            r_gnt   <= '0;
         end
      end
   end

   assign ack     = r_ack;
   assign gnt     = r_gnt;
   assign sel     = r_sel;
   assign o       = r_o;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter plus hand-written reset sequence.
module tb_rr_mux_arbiter;

   localparam int N = 4, W = 8, SELW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*W-1:0]  in_bus;
   logic [N-1:0]    ack, gnt;
   logic [SELW-1:0] sel;
   logic [W-1:0]    o;
   logic            o_valid, o_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.N(N), .W(W), .SELW(SELW)) dut (
      .clk(clk), .rst(rst), .req(req), .in(in_bus), .ack(ack), .gnt(gnt),
      .sel(sel), .o(o), .o_valid(o_valid), .o_ready(o_ready)
   );

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       vld;
      logic [3:0] gnt;
      logic [3:0] ack;
      logic [1:0] sel;
      logic [7:0] o;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] r, input logic rd, input logic v,
                      input logic [3:0] g, input logic [3:0] a,
                      input logic [1:0] s, input logic [7:0] d);
      vec_t t;
      t.req = r; t.rdy = rd; t.vld = v; t.gnt = g; t.ack = a; t.sel = s; t.o = d;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic v, input logic [3:0] g,
                      input logic [3:0] a, input logic [1:0] s, input logic [7:0] d);
      checks++;
      if (o_valid !== v || gnt !== g || ack !== a || sel !== s || o !== d) begin
         errors++;
         $display("FAIL %s: got vld=%b gnt=%b ack=%b sel=%0d o=%h, want vld=%b gnt=%b ack=%b sel=%0d o=%h",
                  name, o_valid, gnt, ack, sel, o, v, g, a, s, d);
      end
   endtask

   initial begin
      // in[3]=D3, in[2]=A5, in[1]=B1, in[0]=C0
      in_bus  = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
      rst     = 1'b1;
      req     = 4'b1111;
      o_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("reset", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
      @(negedge clk) rst = 1'b0;

`ifdef RR_ARB_FIXED_PRIO_EN
      add(4'b1010, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1);
      add(4'b1010, 0, 1, 4'b0010, 4'b0000, 2'd1, 8'hB1);
      add(4'b1010, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1); // ptr=1 yet 1 beats 3
      add(4'b1010, 1, 1, 4'b1000, 4'b1000, 2'd3, 8'hD3); // 1 masked by its ack
      add(4'b1010, 0, 1, 4'b1000, 4'b0000, 2'd3, 8'hD3);
      add(4'b1010, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd1, 8'hB1);
`else
      // all requesting, back-to-back rotation 0,1,2,3,0
      add(4'b1111, 1, 1, 4'b0001, 4'b0001, 2'd0, 8'hC0);
      add(4'b1111, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1);
      add(4'b1111, 1, 1, 4'b0100, 4'b0100, 2'd2, 8'hA5);
      add(4'b1111, 1, 1, 4'b1000, 4'b1000, 2'd3, 8'hD3);
      add(4'b1111, 1, 1, 4'b0001, 4'b0001, 2'd0, 8'hC0);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 8'hC0);
      // single requester 2
      add(4'b0100, 1, 1, 4'b0100, 4'b0100, 2'd2, 8'hA5);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd2, 8'hA5);
      // set ptr=3, then 1001 with downstream stalled
      add(4'b1000, 1, 1, 4'b1000, 4'b1000, 2'd3, 8'hD3);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd3, 8'hD3);
      add(4'b1001, 0, 1, 4'b0001, 4'b0001, 2'd0, 8'hC0);
      for (int i = 0; i < 5; i++)
         add(4'b1001, 0, 1, 4'b0001, 4'b0000, 2'd0, 8'hC0);
      add(4'b1000, 1, 1, 4'b1000, 4'b1000, 2'd3, 8'hD3);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd3, 8'hD3);
      // requester 1 holds req through its ack cycle
      add(4'b0010, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1);
      add(4'b0010, 1, 0, 4'b0000, 4'b0000, 2'd1, 8'hB1);
      add(4'b0010, 1, 1, 4'b0010, 4'b0010, 2'd1, 8'hB1);
      add(4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd1, 8'hB1);
`endif

      foreach (tbl[i]) begin
         req     = tbl[i].req;
         o_ready = tbl[i].rdy;
         @(posedge clk);
         #1 chk($sformatf("vec%0d", i), tbl[i].vld, tbl[i].gnt, tbl[i].ack,
                tbl[i].sel, tbl[i].o);
      end

      // reset while a word is held with its ack outstanding
      req = 4'b0100; o_ready = 1'b0;
      @(posedge clk);
      #1 chk("pre_rst_cap", 1'b1, 4'b0100, 4'b0100, 2'd2, 8'hA5);
      rst = 1'b1; req = 4'b1111; o_ready = 1'b1;
      #1 chk("rst_async", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
      @(posedge clk);
      #1 chk("rst_held", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("post_rst_cap0", 1'b1, 4'b0001, 4'b0001, 2'd0, 8'hC0);
      req = 4'b0000;
      @(posedge clk);
      #1 chk("post_rst_idle", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'hC0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
